// File: rtl/outer1bits_fill.sv
// -----------------------------------------------------------------------------
// outer1bits_fill
//
// Purpose:
//   Builds the "filled span" mask between two one-hot masks. One mask marks
//   the leftmost set bit and the other marks the rightmost set bit. The result
//   has every bit from the right bit up to the left bit set, inclusive. The
//   module also reports the number of set bits in the result, and it flags an
//   illegal pair of masks.
//
//   A pair is legal in two cases:
//     - both masks are zero, or
//     - both masks are one-hot and left >= right.
//   Every other pair is illegal. An illegal pair returns data_o = 0,
//   span_len_o = 0 and error_o = 1.
//
//   Default build: an iterative walk through the FILL state. A cursor starts
//   at the right bit and shifts left once per cycle until it reaches the
//   latched left bit. A span of L bits therefore spends exactly L cycles in
//   FILL.
//
//   Optional build, enabled by defining OUTER1BITS_FILL_FAST_EN: the span is
//   computed combinationally, and every accepted pair goes straight from
//   IDLE to DONE.
//
// Parameters:
//   WIDTH         mask / span width (2..32)
//
// Ports:
//   clk_i         clock; all state updates on its rising edge
//   rst_n_i       asynchronous active-low reset
//   data_val_i    input masks valid
//   data_left_i   one-hot leftmost-set-bit mask, or zero
//   data_right_i  one-hot rightmost-set-bit mask, or zero
//   data_ready_o  block can accept an input (high only in IDLE)
//   data_val_o    result valid (high only in DONE)
//   data_ready_i  downstream accepts the result
//   data_o        filled span mask
//   span_len_o    number of set bits in data_o
//   error_o       input pair was illegal; qualified by data_val_o
// -----------------------------------------------------------------------------
module outer1bits_fill #(
    parameter int WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       data_val_i,
    input  logic [WIDTH-1:0]           data_left_i,
    input  logic [WIDTH-1:0]           data_right_i,
    output logic                       data_ready_o,
    output logic                       data_val_o,
    input  logic                       data_ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(WIDTH+1)-1:0] span_len_o,
    output logic                       error_o
);

    localparam int LW = $clog2(WIDTH+1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] cursor_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] left_reg;
    logic [LW-1:0]    len_reg;
    logic             err_reg;

    // Legality of the presented pair.
    // x & (x-1) clears the lowest set bit, so a nonzero x is one-hot exactly
    // when that result is zero. For one-hot masks, comparing them as numbers
    // is the same as comparing their bit indices.
    logic left_onehot;
    logic right_onehot;
    logic pair_zero;
    logic pair_legal;

    assign left_onehot  = (data_left_i != '0) &&
                          ((data_left_i & (data_left_i - ONE)) == '0);
    assign right_onehot = (data_right_i != '0) &&
                          ((data_right_i & (data_right_i - ONE)) == '0);
    assign pair_zero    = (data_left_i == '0) && (data_right_i == '0);
    assign pair_legal   = pair_zero ||
                          (left_onehot && right_onehot &&
                           (data_left_i >= data_right_i));

`ifdef OUTER1BITS_FILL_FAST_EN
    // (left | left-1) keeps the left bit and every bit below it.
    // ~(right-1) keeps the right bit and every bit above it.
    // Their intersection is the inclusive span.
    logic [WIDTH-1:0] span_fast;
    logic [LW-1:0]    pc [0:WIDTH];

    assign span_fast = (data_left_i | (data_left_i - ONE)) &
                       ~(data_right_i - ONE);

    // Prefix-sum population count of the span.
    assign pc[0] = '0;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_popcnt
        assign pc[gi+1] = pc[gi] + LW'(span_fast[gi]);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            cursor_reg <= '0;
            acc_reg    <= '0;
            left_reg   <= '0;
            len_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (data_val_i) begin
                        err_reg <= !pair_legal;
`ifdef OUTER1BITS_FILL_FAST_EN
                        acc_reg   <= (pair_legal && !pair_zero) ? span_fast : '0;
                        len_reg   <= (pair_legal && !pair_zero) ? pc[WIDTH] : '0;
                        state_reg <= DONE;
`else
                        acc_reg    <= '0;
                        len_reg    <= '0;
                        cursor_reg <= data_right_i;
                        left_reg   <= data_left_i;
                        // Zero and illegal pairs skip the walk.
                        state_reg  <= (pair_legal && !pair_zero) ? FILL : DONE;
`endif
                    end
                end
                FILL: begin
                    acc_reg    <= acc_reg | cursor_reg;
                    len_reg    <= len_reg + LW'(1);
                    cursor_reg <= cursor_reg << 1;
                    // left >= right is guaranteed, so the cursor always
                    // reaches the left bit before it could shift out.
                    if (cursor_reg == left_reg) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (data_ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_ready_o = (state_reg == IDLE);
    assign data_val_o   = (state_reg == DONE);

    // Outputs read zero outside DONE, so a partially filled accumulator is
    // never visible.
    assign data_o     = data_val_o ? acc_reg : '0;
    assign span_len_o = data_val_o ? len_reg : '0;
    assign error_o    = data_val_o ? err_reg : 1'b0;

endmodule

// File: tb/tb_outer1bits_fill.sv
// -----------------------------------------------------------------------------
// tb_outer1bits_fill
//
// Scoreboard bench for outer1bits_fill with WIDTH=4.
//
// The stimulus process does three things:
//   - drives directed vectors,
//   - pushes the hand-computed result for each vector into a queue,
//   - checks handshake timing.
//
// A separate monitor samples on the falling clock edge. Whenever data_val_o
// is high it compares the outputs against the head of the queue, and it pops
// that entry once data_ready_i is high (the delivery cycle).
// -----------------------------------------------------------------------------
module tb_outer1bits_fill;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] len;
        logic       err;
    } exp_t;

    logic       clk_i;
    logic       rst_n_i;
    logic       data_val_i;
    logic [3:0] data_left_i;
    logic [3:0] data_right_i;
    logic       data_ready_o;
    logic       data_val_o;
    logic       data_ready_i;
    logic [3:0] data_o;
    logic [2:0] span_len_o;
    logic       error_o;

    exp_t sb[$];
    int   checks;
    int   failures;

    outer1bits_fill #(.WIDTH(4)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_val_i   (data_val_i),
        .data_left_i  (data_left_i),
        .data_right_i (data_right_i),
        .data_ready_o (data_ready_o),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i),
        .data_o       (data_o),
        .span_len_o   (span_len_o),
        .error_o      (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares on every DONE cycle, so the results are also checked
    // for stability while held.
    always @(negedge clk_i) begin
        if (rst_n_i && data_val_o) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got data=%b len=%0d err=%b expected no output",
                         data_o, span_len_o, error_o);
            end else begin
                if ({data_o, span_len_o, error_o} !== sb[0]) begin
                    failures++;
                    $display("FAIL result: got data=%b len=%0d err=%b expected data=%b len=%0d err=%b",
                             data_o, span_len_o, error_o, sb[0].d, sb[0].len, sb[0].err);
                end
                if (data_ready_i) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Advances one edge, then waits until the outputs have settled.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    // Returns the number of edges, counting the accepting edge as 1, until
    // data_val_o is seen high. The wait is bounded to 20 edges.
    task automatic wait_result(output int n);
        n = 1;
        while (!data_val_o && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic send(input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] ed, input logic [2:0] el, input logic ee,
                        input int lat, input int hold);
        int n;
        int want;
        want = lat;
`ifdef OUTER1BITS_FILL_FAST_EN
        want = 1;
`endif
        check("ready_idle", data_ready_o, 1);
        sb.push_back({ed, el, ee});
        data_left_i  = l;
        data_right_i = r;
        data_val_i   = 1'b1;
        data_ready_i = (hold == 0);
        step();
        // This stray pair must be ignored outside IDLE.
        data_val_i   = 1'b0;
        data_left_i  = 4'b0010;
        data_right_i = 4'b0001;
        wait_result(n);
        check("latency", n, want);
        if (hold > 0) begin
            data_val_i = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                check("hold_valid", data_val_o, 1);
                check("hold_not_ready", data_ready_o, 0);
            end
            data_val_i   = 1'b0;
            data_ready_i = 1'b1;
        end
        step();
        check("post_deliver_ready", data_ready_o, 1);
        check("post_deliver_val", data_val_o, 0);
        $display("txn left=%b right=%b -> data=%b len=%0d err=%b latency=%0d", l, r, ed, el, ee, n);
    endtask

    initial begin
        int  n;
        int  want;
        logic seen;
        checks       = 0;
        failures     = 0;
        data_val_i   = 1'b0;
        data_left_i  = '0;
        data_right_i = '0;
        data_ready_i = 1'b1;
        rst_n_i      = 1'b1;
        #1 rst_n_i   = 1'b0;
        #1;
        check("rst_val", data_val_o, 0);
        check("rst_data", data_o, 0);
        check("rst_len", span_len_o, 0);
        check("rst_err", error_o, 0);
        check("rst_ready", data_ready_o, 1);
        step();
        step();
        rst_n_i = 1'b1;
        step();

        send(4'b1000, 4'b0001, 4'b1111, 3'd4, 1'b0, 5, 0);
        send(4'b0100, 4'b0100, 4'b0100, 3'd1, 1'b0, 2, 0);
        send(4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0, 1, 0);
        send(4'b0001, 4'b0100, 4'b0000, 3'd0, 1'b1, 1, 0);
        send(4'b0110, 4'b0010, 4'b0000, 3'd0, 1'b1, 1, 0);
        send(4'b0000, 4'b1000, 4'b0000, 3'd0, 1'b1, 1, 0);
        send(4'b0100, 4'b0010, 4'b0110, 3'd2, 1'b0, 3, 3);
        send(4'b1000, 4'b0010, 4'b1110, 3'd3, 1'b0, 4, 0);

        // Back-to-back: data_val_i is held high across two pairs.
        sb.push_back({4'b0011, 3'd2, 1'b0});
        sb.push_back({4'b0100, 3'd1, 1'b0});
        data_val_i   = 1'b1;
        data_left_i  = 4'b0010;
        data_right_i = 4'b0001;
        data_ready_i = 1'b1;
        step();
        data_left_i  = 4'b0100;
        data_right_i = 4'b0100;
        wait_result(n);
        want = 3;
`ifdef OUTER1BITS_FILL_FAST_EN
        want = 1;
`endif
        check("b2b_first_latency", n, want);
        step();   // delivery edge
        check("b2b_idle_after_deliver", data_ready_o, 1);
        step();   // second pair accepted here
        check("b2b_second_accepted", data_ready_o, 0);
        data_val_i = 1'b0;
        wait_result(n);
        want = 2;
`ifdef OUTER1BITS_FILL_FAST_EN
        want = 1;
`endif
        check("b2b_second_latency", n, want);
        step();
        check("b2b_done_ready", data_ready_o, 1);
        $display("txn back-to-back 0010/0001 then 0100/0100 done");

        // Reset during the second FILL cycle of 1000/0001. The result is never
        // delivered.
        data_ready_i = 1'b0;
`ifdef OUTER1BITS_FILL_FAST_EN
        sb.push_back({4'b1111, 3'd4, 1'b0});
`endif
        data_val_i   = 1'b1;
        data_left_i  = 4'b1000;
        data_right_i = 4'b0001;
        step();
        data_val_i = 1'b0;
        step();
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_val", data_val_o, 0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_len", span_len_o, 0);
        check("mid_rst_err", error_o, 0);
        check("mid_rst_ready", data_ready_o, 1);
        sb.delete();
        step();
        step();
        rst_n_i      = 1'b1;
        data_ready_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | data_val_o;
        end
        check("no_output_after_rst", seen, 0);
        $display("txn reset during FILL of 1000/0001 -> abandoned");

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/outer1bits_fill.md
OUTER1BITS_FILL -- requirements
Module: outer1bits_fill

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the bit width of the mask inputs and the span output (legal 2..32).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port data_val_i, input, 1, input masks valid.
REQ-005 SHALL have port data_left_i, input, WIDTH, one-hot leftmost-set-bit mask or zero.
REQ-006 SHALL have port data_right_i, input, WIDTH, one-hot rightmost-set-bit mask or zero.
REQ-007 SHALL have port data_ready_o, output, 1, block can accept an input.
REQ-008 SHALL have port data_val_o, output, 1, result valid.
REQ-009 SHALL have port data_ready_i, input, 1, downstream accepts the result.
REQ-010 SHALL have port data_o, output, WIDTH, filled span mask: all bits from the right bit to the left bit inclusive.
REQ-011 SHALL have port span_len_o, output, $clog2(WIDTH+1), number of set bits in data_o.
REQ-012 SHALL have port error_o, output, 1, input pair is illegal; qualified by data_val_o.

Function
REQ-013 SHALL accept an input only on a rising edge where data_val_i and data_ready_o are both 1; data_ready_o SHALL be 1 only in IDLE.
REQ-014 SHALL implement states IDLE, FILL and DONE.
REQ-015 SHALL treat the pair as legal when both masks are zero, or when both are one-hot and the left index is greater than or equal to the right index; every other pair is illegal.
REQ-016 SHALL, on acceptance of a legal nonzero pair, load cursor=data_right_i, clear the accumulator, latch data_left_i, and go IDLE->FILL.
REQ-017 SHALL, in each FILL cycle, OR the cursor into the accumulator, increment the length counter, and shift the cursor left by one.
REQ-018 SHALL go FILL->DONE on the edge that processes the cursor equal to the latched left mask, so a span of L bits spends exactly L cycles in FILL.
REQ-019 SHALL, on acceptance of a zero/zero pair, go IDLE->DONE with data_o=0, span_len_o=0, error_o=0.
REQ-020 SHALL, on acceptance of an illegal pair, go IDLE->DONE with data_o=0, span_len_o=0, error_o=1.
REQ-021 SHALL assert data_val_o exactly in DONE and hold data_o, span_len_o and error_o stable until data_ready_i is 1.
REQ-022 SHALL go DONE->IDLE on the edge where data_ready_i is 1; there is no accept/deliver overlap, so the next input is accepted no earlier than the following edge.
REQ-023 SHALL keep the length counter within its range; the maximum L=WIDTH SHALL be representable without wrap.
REQ-024 SHALL ignore data_val_i, data_left_i and data_right_i outside IDLE.

Reset
REQ-025 SHALL, while rst_n_i=0, set the state to IDLE and force data_val_o=0, data_o=0, span_len_o=0, error_o=0, data_ready_o=1, independent of clk_i.
REQ-026 SHALL abandon an in-progress FILL or an undelivered DONE result when reset asserts, and SHALL produce no output for it after reset.

Configuration
REQ-027 SHALL, with macro OUTER1BITS_FILL_FAST_EN defined, compute the span combinationally from the masks and go IDLE->DONE on the accepting edge for every pair (result latency 1 edge); outputs, error rules and handshake are otherwise identical.
REQ-028 SHALL, without OUTER1BITS_FILL_FAST_EN, use the iterative FILL walk of REQ-016..REQ-018.

Verification (WIDTH=4, default build unless noted)
REQ-029 SHALL cover: left=1000, right=0001 accepted with data_ready_i=1 -> data_val_o rises 5 edges after acceptance, data_o=1111, span_len_o=4, error_o=0; in FAST build -> data_val_o rises 1 edge after acceptance.
REQ-030 SHALL cover: left=right=0100 -> data_o=0100, span_len_o=1, data_val_o rises 2 edges after acceptance.
REQ-031 SHALL cover: left=0000, right=0000 -> data_o=0000, span_len_o=0, error_o=0, data_val_o rises 1 edge after acceptance; illegal pairs left=0001/right=0100 and left=0110/right=0010 -> error_o=1, data_o=0000.
REQ-032 SHALL cover: data_ready_i=0 for 3 cycles in DONE -> outputs held, data_ready_o=0, and a new data_val_i with left=0010, right=0001 presented in that window is not accepted.
REQ-033 SHALL cover: rst_n_i pulsed low during the second FILL cycle of left=1000/right=0001 -> all outputs 0 immediately, data_ready_o=1, and no data_val_o occurs afterwards.
REQ-034 SHALL cover: back-to-back inputs with data_val_i held high -> the second pair is accepted exactly 1 edge after the first result's delivery edge.
